// File: rtl/decode_pkg.sv
// Package decode_pkg
// Shared types and constants for the wide decode stage.
//   INSTR_W        instruction / immediate width
//   OPC_*          RV32I major opcodes recognised by the lane decoder
//   fu_type_e      functional unit a uop is steered to
//   alu_op_e       coarse ALU operation class handed to the execute stage
//   decoded_uop_t  one decoded instruction, packed so lanes can be flattened
//   UOP_W          width of decoded_uop_t in bits
package decode_pkg;

    localparam int INSTR_W = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_BR  = 2'd1,
        FU_LSU = 2'd2
    } fu_type_e;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_FUNCT  = 2'b10,
        ALU_OP_LUI    = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [INSTR_W-1:0] imm;
        logic               alu_src;
        logic               branch;
        alu_op_e            alu_op;
        fu_type_e           fu_type;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic [2:0]         funct3;
        logic               funct7b5;
        logic               illegal;
    } decoded_uop_t;

    localparam int UOP_W = $bits(decoded_uop_t);

endpackage

// File: rtl/decode_lane.sv
// Module decode_lane
// Purely combinational decoder for a single RV32I instruction.
//   instr  in   INSTR_W        raw instruction word
//   uop    out  decoded_uop_t  decoded fields, immediate and control bits
module decode_lane
    import decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decoded_uop_t       uop
);

    logic [INSTR_W-1:0] imm_i;
    logic [INSTR_W-1:0] imm_s;
    logic [INSTR_W-1:0] imm_b;
    logic [INSTR_W-1:0] imm_u;
    logic [INSTR_W-1:0] imm_j;

    // Every immediate format is built up front and sign-extended from bit 31;
    // the opcode case below only picks which one applies.
    always_comb begin
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'b0};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    // Register specifiers and funct bits are passed through raw for every
    // opcode, even illegal ones, so a trap handler can still see them.
    // Unrecognised encodings leave all side-effect controls at zero and only
    // raise illegal; the lane itself stays valid so commit can take the trap.
    // A destination of x0 never writes, whatever the opcode.
    always_comb begin
        uop          = '0;
        uop.rs1      = instr[19:15];
        uop.rs2      = instr[24:20];
        uop.rd       = instr[11:7];
        uop.funct3   = instr[14:12];
        uop.funct7b5 = instr[30];
        case (instr[6:0])
            OPC_OP: begin
                uop.alu_op    = ALU_OP_FUNCT;
                uop.fu_type   = FU_ALU;
                uop.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                uop.imm       = imm_i;
                uop.alu_src   = 1'b1;
                uop.alu_op    = ALU_OP_FUNCT;
                uop.fu_type   = FU_ALU;
                uop.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                uop.imm       = imm_i;
                uop.alu_src   = 1'b1;
                uop.alu_op    = ALU_OP_ADD;
                uop.fu_type   = FU_LSU;
                uop.mem_read  = 1'b1;
                uop.reg_write = 1'b1;
            end
            OPC_STORE: begin
                uop.imm       = imm_s;
                uop.alu_src   = 1'b1;
                uop.alu_op    = ALU_OP_ADD;
                uop.fu_type   = FU_LSU;
                uop.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                uop.imm     = imm_b;
                uop.branch  = 1'b1;
                uop.alu_op  = ALU_OP_BRANCH;
                uop.fu_type = FU_BR;
            end
            OPC_LUI: begin
                uop.imm       = imm_u;
                uop.alu_src   = 1'b1;
                uop.alu_op    = ALU_OP_LUI;
                uop.fu_type   = FU_ALU;
                uop.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                uop.imm       = imm_u;
                uop.alu_src   = 1'b1;
                uop.alu_op    = ALU_OP_ADD;
                uop.fu_type   = FU_ALU;
                uop.reg_write = 1'b1;
            end
            OPC_JAL: begin
                uop.imm       = imm_j;
                uop.branch    = 1'b1;
                uop.alu_op    = ALU_OP_ADD;
                uop.fu_type   = FU_BR;
                uop.reg_write = 1'b1;
            end
            OPC_JALR: begin
                if (instr[14:12] == 3'b000) begin
                    uop.imm       = imm_i;
                    uop.alu_src   = 1'b1;
                    uop.branch    = 1'b1;
                    uop.alu_op    = ALU_OP_ADD;
                    uop.fu_type   = FU_BR;
                    uop.reg_write = 1'b1;
                end else begin
                    uop.illegal = 1'b1;
                end
            end
            default: begin
                uop.illegal = 1'b1;
            end
        endcase
        if (uop.rd == 5'd0) begin
            uop.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage_wide.sv
// Module decode_stage_wide
// Registered DECODE_W-wide decode stage with a one-bundle skid register.
//   clk, reset     rising-edge clock, synchronous active-high reset
//   flush          discard every held and incoming bundle
//   i_valid/o_ready           upstream handshake (o_ready purely registered)
//   i_instr, i_lane_valid, i_pc   incoming bundle, PC of lane 0
//   o_valid/i_ready           downstream handshake
//   o_lane_valid, o_pc, o_uop     decoded bundle, invalid lanes read as zero
module decode_stage_wide
    import decode_pkg::*;
#(
    parameter int DECODE_W = 2,
    parameter int PC_W     = 9,
    parameter int XLEN     = INSTR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [DECODE_W*XLEN-1:0]  i_instr,
    input  logic [DECODE_W-1:0]       i_lane_valid,
    input  logic [PC_W-1:0]           i_pc,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DECODE_W-1:0]       o_lane_valid,
    output logic [DECODE_W*PC_W-1:0]  o_pc,
    output logic [DECODE_W*UOP_W-1:0] o_uop
);

    decoded_uop_t               lane_uop [DECODE_W];
    logic [DECODE_W*PC_W-1:0]   in_pc;
    logic [DECODE_W*UOP_W-1:0]  in_uop;

    logic                       main_valid;
    logic [DECODE_W-1:0]        main_lane_valid;
    logic [DECODE_W*PC_W-1:0]   main_pc;
    logic [DECODE_W*UOP_W-1:0]  main_uop;

    logic                       skid_valid;
    logic [DECODE_W-1:0]        skid_lane_valid;
    logic [DECODE_W*PC_W-1:0]   skid_pc;
    logic [DECODE_W*UOP_W-1:0]  skid_uop;

    logic                       accept;
    logic                       load;
    logic                       fire;

    // Decode happens before the registers, so both main and skid hold
    // finished uops. Lanes that are not valid are zeroed here so nothing
    // downstream ever sees stale fields or PCs.
    for (genvar k = 0; k < DECODE_W; k++) begin : g_lane
        decode_lane u_decode_lane (
            .instr (i_instr[k*XLEN +: XLEN]),
            .uop   (lane_uop[k])
        );
        assign in_uop[k*UOP_W +: UOP_W] = i_lane_valid[k] ? lane_uop[k] : '0;
        assign in_pc[k*PC_W +: PC_W]    = i_lane_valid[k] ? PC_W'(i_pc + PC_W'(4*k)) : '0;
    end

    // A bundle with no valid lanes is still handshaken but never stored,
    // so it silently disappears.
    assign o_ready = ~skid_valid;
    assign accept  = i_valid & o_ready;
    assign load    = accept & (|i_lane_valid);
    assign fire    = main_valid & i_ready;

    // The main register refills from the skid first to keep bundle order;
    // a new bundle only parks in the skid when main is full and stalled.
    // Flush and reset only clear the valid bits; the data registers are
    // masked at the outputs instead of being cleared.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || fire) begin
            if (skid_valid) begin
                main_valid      <= 1'b1;
                main_lane_valid <= skid_lane_valid;
                main_pc         <= skid_pc;
                main_uop        <= skid_uop;
                skid_valid      <= load;
                if (load) begin
                    skid_lane_valid <= i_lane_valid;
                    skid_pc         <= in_pc;
                    skid_uop        <= in_uop;
                end
            end else begin
                main_valid <= load;
                if (load) begin
                    main_lane_valid <= i_lane_valid;
                    main_pc         <= in_pc;
                    main_uop        <= in_uop;
                end
            end
        end else if (load) begin
            skid_valid      <= 1'b1;
            skid_lane_valid <= i_lane_valid;
            skid_pc         <= in_pc;
            skid_uop        <= in_uop;
        end
    end

    // Outputs read as all zero whenever the main register is empty.
    assign o_valid      = main_valid;
    assign o_lane_valid = main_valid ? main_lane_valid : '0;
    assign o_pc         = main_valid ? main_pc : '0;
    assign o_uop        = main_valid ? main_uop : '0;

endmodule

// File: tb/tb_decode_stage_wide.sv
// Testbench tb_decode_stage_wide
// Directed vector table plus hand-written handshake, flush and reset
// sequences, then a random-handshake soak against a scoreboard queue.
module tb_decode_stage_wide;
    import decode_pkg::*;

    localparam int DW   = 2;
    localparam int PC_W = 9;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush;
    logic                  i_valid;
    logic                  o_ready;
    logic [DW*32-1:0]      i_instr;
    logic [DW-1:0]         i_lane_valid;
    logic [PC_W-1:0]       i_pc;
    logic                  o_valid;
    logic                  i_ready;
    logic [DW-1:0]         o_lane_valid;
    logic [DW*PC_W-1:0]    o_pc;
    logic [DW*UOP_W-1:0]   o_uop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage_wide #(.DECODE_W(DW), .PC_W(PC_W), .XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_instr      (i_instr),
        .i_lane_valid (i_lane_valid),
        .i_pc         (i_pc),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_lane_valid (o_lane_valid),
        .o_pc         (o_pc),
        .o_uop        (o_uop)
    );

    typedef struct {
        string             name;
        logic [31:0]       instr0;
        logic [31:0]       instr1;
        logic [PC_W-1:0]   pc;
        logic [1:0]        lane_valid;
        logic [PC_W-1:0]   exp_pc0;
        logic [PC_W-1:0]   exp_pc1;
        logic [UOP_W-1:0]  exp_uop0;
        logic [UOP_W-1:0]  exp_uop1;
    } vec_t;

    // Expected uop laid out field by field in decoded_uop_t order.
    function automatic logic [UOP_W-1:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
            input logic [4:0] rd, input logic [31:0] imm, input logic alu_src,
            input logic branch, input logic [1:0] alu_op, input logic [1:0] fu,
            input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
            input logic f7, input logic ill);
        return {rs1, rs2, rd, imm, alu_src, branch, alu_op, fu, mr, mw, rw, f3, f7, ill};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr0,
            input logic [31:0] instr1, input logic [PC_W-1:0] pc, input logic [1:0] lane_valid);
        i_valid      = valid;
        i_instr      = {instr1, instr0};
        i_pc         = pc;
        i_lane_valid = lane_valid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_NOP  = 32'h00000013;
    localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;
    localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
    localparam logic [31:0] I_LW   = 32'h0040A103;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_JALR = 32'h000010E7;

    vec_t vecs [5];
    logic [UOP_W-1:0] u_addi, u_add, u_nop, u_ill, u_beq, u_lw, u_lui, u_jalr;
    decoded_uop_t     soak_uop;
    logic [11:0]      exp_q [$];
    logic [1:0]       exp_lv_q [$];

    initial begin
        u_addi = mk(5'd0, 5'd5, 5'd1, 32'd5, 1'b1, 1'b0, 2'b10, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        u_add  = mk(5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0, 2'b10, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        u_nop  = mk(5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 2'b10, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        u_ill  = mk(5'd31, 5'd31, 5'd31, 32'd0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1);
        u_beq  = mk(5'd0, 5'd0, 5'd29, 32'hFFFFFFFC, 1'b0, 1'b1, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        u_lw   = mk(5'd1, 5'd4, 5'd2, 32'd4, 1'b1, 1'b0, 2'b00, 2'd2, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        u_lui  = mk(5'd8, 5'd3, 5'd5, 32'h12345000, 1'b1, 1'b0, 2'b11, 2'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        u_jalr = mk(5'd0, 5'd0, 5'd1, 32'd0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1);

        vecs[0] = '{"addi_add", I_ADDI, I_ADD, 9'h010, 2'b11, 9'h010, 9'h014, u_addi, u_add};
        vecs[1] = '{"nop_illegal", I_NOP, I_ILL, 9'h030, 2'b11, 9'h030, 9'h034, u_nop, u_ill};
        vecs[2] = '{"beq_lw_wrap", I_BEQ, I_LW, 9'h1FC, 2'b11, 9'h1FC, 9'h000, u_beq, u_lw};
        vecs[3] = '{"lui_badjalr", I_LUI, I_JALR, 9'h100, 2'b11, 9'h100, 9'h104, u_lui, u_jalr};
        vecs[4] = '{"lane0_only", I_ADDI, I_ADD, 9'h050, 2'b01, 9'h050, 9'h000, u_addi, '0};

        reset   = 1'b1;
        flush   = 1'b0;
        i_ready = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, '0, 2'b00);
        step();
        step();
        checkOutput("reset_o_valid", 64'(o_valid), 64'd0);
        checkOutput("reset_o_ready", 64'(o_ready), 64'd1);
        checkOutput("reset_lane_valid", 64'(o_lane_valid), 64'd0);
        checkOutput("reset_o_pc", 64'(o_pc), 64'd0);
        checkOutput("reset_o_uop", 64'(o_uop[UOP_W-1:0]), 64'd0);
        reset = 1'b0;
        step();

        $display("[TB] vector table");
        for (int v = 0; v < 5; v++) begin
            applyStimulus(1'b1, vecs[v].instr0, vecs[v].instr1, vecs[v].pc, vecs[v].lane_valid);
            step();
            i_valid = 1'b0;
            checkOutput({vecs[v].name, "_valid"}, 64'(o_valid), 64'd1);
            checkOutput({vecs[v].name, "_lane_valid"}, 64'(o_lane_valid), 64'(vecs[v].lane_valid));
            checkOutput({vecs[v].name, "_pc0"}, 64'(o_pc[0 +: PC_W]), 64'(vecs[v].exp_pc0));
            checkOutput({vecs[v].name, "_pc1"}, 64'(o_pc[PC_W +: PC_W]), 64'(vecs[v].exp_pc1));
            checkOutput({vecs[v].name, "_uop0"}, 64'(o_uop[0 +: UOP_W]), 64'(vecs[v].exp_uop0));
            checkOutput({vecs[v].name, "_uop1"}, 64'(o_uop[UOP_W +: UOP_W]), 64'(vecs[v].exp_uop1));
        end
        step();
        checkOutput("drained_valid", 64'(o_valid), 64'd0);

        $display("[TB] empty bundle");
        applyStimulus(1'b1, I_ADDI, I_ADD, 9'h070, 2'b00);
        step();
        i_valid = 1'b0;
        checkOutput("empty_bundle_valid", 64'(o_valid), 64'd0);
        checkOutput("empty_bundle_ready", 64'(o_ready), 64'd1);

        $display("[TB] backpressure and skid");
        i_ready = 1'b0;
        applyStimulus(1'b1, I_ADDI, I_ADD, 9'h020, 2'b11);
        step();
        checkOutput("bp_first_ready", 64'(o_ready), 64'd1);
        applyStimulus(1'b1, I_ADDI, I_ADD, 9'h040, 2'b11);
        step();
        checkOutput("bp_second_ready", 64'(o_ready), 64'd0);
        applyStimulus(1'b1, I_ADDI, I_ADD, 9'h060, 2'b11);
        step();
        checkOutput("bp_third_held_ready", 64'(o_ready), 64'd0);
        checkOutput("bp_head_pc", 64'(o_pc[0 +: PC_W]), 64'h020);
        i_ready = 1'b1;
        step();
        checkOutput("bp_second_out_pc", 64'(o_pc[0 +: PC_W]), 64'h040);
        checkOutput("bp_ready_back", 64'(o_ready), 64'd1);
        step();
        i_valid = 1'b0;
        checkOutput("bp_third_out_pc", 64'(o_pc[0 +: PC_W]), 64'h060);
        checkOutput("bp_third_valid", 64'(o_valid), 64'd1);
        step();
        checkOutput("bp_empty", 64'(o_valid), 64'd0);

        $display("[TB] flush with main and skid full");
        i_ready = 1'b0;
        applyStimulus(1'b1, I_ADDI, I_ADD, 9'h080, 2'b11);
        step();
        applyStimulus(1'b1, I_ADDI, I_ADD, 9'h090, 2'b11);
        step();
        checkOutput("flush_pre_ready", 64'(o_ready), 64'd0);
        applyStimulus(1'b1, I_ADDI, I_ADD, 9'h0A0, 2'b11);
        i_ready = 1'b1;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
        i_valid = 1'b0;
        checkOutput("flush_valid", 64'(o_valid), 64'd0);
        checkOutput("flush_ready", 64'(o_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("flush_stays_empty", 64'(o_valid), 64'd0);
        end

        $display("[TB] reset mid-transfer");
        i_ready = 1'b0;
        applyStimulus(1'b1, I_LUI, I_LW, 9'h0C0, 2'b11);
        step();
        step();
        i_valid = 1'b0;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        i_ready = 1'b1;
        checkOutput("midreset_valid", 64'(o_valid), 64'd0);
        checkOutput("midreset_ready", 64'(o_ready), 64'd1);
        checkOutput("midreset_pc", 64'(o_pc), 64'd0);
        step();
        checkOutput("midreset_no_ghost", 64'(o_valid), 64'd0);

        $display("[TB] random handshake soak");
        for (int c = 0; c < 400; c++) begin
            logic [11:0] tag;
            logic [1:0]  lv;
            tag = 12'(c + 1);
            case ($urandom_range(0, 3))
                0:       lv = 2'b00;
                1:       lv = 2'b01;
                default: lv = 2'b11;
            endcase
            applyStimulus(1'($urandom_range(0, 1)), {tag, 5'd0, 3'd0, 5'd1, 7'h13}, I_ADD,
                          PC_W'(tag * 4), lv);
            i_ready = 1'($urandom_range(0, 2) != 0);
            if (o_valid && i_ready) begin
                soak_uop = o_uop[0 +: UOP_W];
                if (exp_q.size() == 0) begin
                    checkOutput("soak_unexpected_bundle", 64'(soak_uop.imm[11:0]), 64'hFFF);
                end else begin
                    logic [11:0] exp_tag;
                    logic [1:0]  exp_lv;
                    exp_tag = exp_q.pop_front();
                    exp_lv  = exp_lv_q.pop_front();
                    checkOutput("soak_tag", 64'(soak_uop.imm[11:0]), 64'(exp_tag));
                    checkOutput("soak_pc_lv", 64'({o_lane_valid, o_pc[0 +: PC_W]}),
                                64'({exp_lv, PC_W'(exp_tag * 4)}));
                end
            end
            if (i_valid && o_ready && lv != 2'b00) begin
                exp_q.push_back(tag);
                exp_lv_q.push_back(lv);
            end
            step();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            if (o_valid) begin
                logic [11:0] exp_tag;
                logic [1:0]  exp_lv;
                soak_uop = o_uop[0 +: UOP_W];
                exp_tag  = exp_q.pop_front();
                exp_lv   = exp_lv_q.pop_front();
                checkOutput("drain_tag", 64'(soak_uop.imm[11:0]), 64'(exp_tag));
                checkOutput("drain_lv", 64'(o_lane_valid), 64'(exp_lv));
            end
            step();
        end
        checkOutput("soak_leftover", 64'(exp_q.size()), 64'd0);
        checkOutput("soak_final_valid", 64'(o_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
